// File: rtl/br_resolve_unit_pkg.sv
// Shared RV32I types for the branch path.
//   branch_funct3_t : funct3 encodings of the six conditional branches
//   bht_ctr_t       : 2-bit saturating BHT counter, plus its named states
//   ctr_next()      : saturating counter step toward taken / not-taken
package rv32i_types;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  function automatic bht_ctr_t ctr_next(bht_ctr_t c, logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
    else       return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/br_resolve_unit_if.sv
// Bus between fetch/issue and the branch resolve stage.
//   master : drives prediction lookup PC and the resolving branch op
//   slave  : the resolve unit; returns prediction, registered result, stats
interface br_resolve_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            res_valid;
  logic [2:0]      res_cmpop;
  logic [XLEN-1:0] res_a;
  logic [XLEN-1:0] res_b;
  logic [XLEN-1:0] res_pc;
  logic            res_pred;
  logic            stall;
  logic            flush;
  logic            out_valid;
  logic            br_en;
  logic            mispredict;
  logic            illegal_op;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output pred_pc, res_valid, res_cmpop, res_a, res_b, res_pc, res_pred, stall, flush,
    input  pred_taken, out_valid, br_en, mispredict, illegal_op, branch_count, mispredict_count
  );
  modport slave (
    input  pred_pc, res_valid, res_cmpop, res_a, res_b, res_pc, res_pred, stall, flush,
    output pred_taken, out_valid, br_en, mispredict, illegal_op, branch_count, mispredict_count
  );
endinterface

// File: rtl/br_resolve_unit_cmp.sv
// br_cmp: combinational branch condition evaluator, shared with the ALU path.
//   cmpop   : branch funct3
//   a, b    : operands (XLEN)
//   br_en   : condition true
//   illegal : funct3 010/011, which encode no branch (br_en forced 0)
module br_cmp
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      cmpop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            br_en,
  output logic            illegal
);
  always_comb begin
    br_en   = 1'b0;
    illegal = 1'b0;
    case (cmpop)
      BR_BEQ:  br_en = (a == b);
      BR_BNE:  br_en = (a != b);
      BR_BLT:  br_en = ($signed(a) <  $signed(b));
      BR_BGE:  br_en = ($signed(a) >= $signed(b));
      BR_BLTU: br_en = (a <  b);
      BR_BGEU: br_en = (a >= b);
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolution stage with bimodal BHT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lookup (pred_pc -> pred_taken, combinational) and resolve
//              (res_* -> registered out_valid/br_en/mispredict/illegal_op),
//              plus saturating branch and mispredict counts
// The BHT is trained on the resolve edge; a same-index lookup in that cycle
// sees the pre-update counter (no bypass).
module br_resolve_unit
  import rv32i_types::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BHT_ENTRIES = 64,
  parameter bht_ctr_t CTR_INIT    = CTR_WNT
) (
  input logic              clk,
  input logic              rst,
  br_resolve_unit_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);

  bht_ctr_t [BHT_ENTRIES-1:0] bht;
  logic [IW-1:0] pred_idx, res_idx;
  logic          cmp_br, cmp_ill, fire;
  logic          vld_q, br_q, mis_q, ill_q;
  logic [31:0]   bcnt, mcnt;

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .cmpop   (bus.res_cmpop),
    .a       (bus.res_a),
    .b       (bus.res_b),
    .br_en   (cmp_br),
    .illegal (cmp_ill)
  );

  // Word-aligned PCs: bits [1:0] carry no index information.
  assign pred_idx = bus.pred_pc[IW+1:2];
  assign res_idx  = bus.res_pc[IW+1:2];
  assign fire     = bus.res_valid & ~bus.stall & ~bus.flush;

  assign bus.pred_taken       = bht[pred_idx][1];
  assign bus.out_valid        = vld_q;
  assign bus.br_en            = br_q;
  assign bus.mispredict       = mis_q;
  assign bus.illegal_op       = ill_q;
  assign bus.branch_count     = bcnt;
  assign bus.mispredict_count = mcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bht   <= {BHT_ENTRIES{CTR_INIT}};
      vld_q <= 1'b0;
      br_q  <= 1'b0;
      mis_q <= 1'b0;
      ill_q <= 1'b0;
      bcnt  <= '0;
      mcnt  <= '0;
    end else if (fire) begin
      vld_q <= 1'b1;
      br_q  <= cmp_br;
      mis_q <= cmp_br ^ bus.res_pred;
      ill_q <= cmp_ill;
      // Illegal encodings are not branches: no training, no stats.
      if (!cmp_ill) begin
        bht[res_idx] <= ctr_next(bht[res_idx], cmp_br);
        if (bcnt != '1) bcnt <= bcnt + 32'd1;
        if ((cmp_br != bus.res_pred) && (mcnt != '1)) mcnt <= mcnt + 32'd1;
      end
    end else if (bus.flush || !bus.stall) begin
      // Stall without flush holds everything, out_valid included.
      vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;
  localparam int  N   = 64;
  localparam longint SAT = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_resolve_unit_if #(.XLEN(32)) bus ();

  br_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N), .CTR_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit     v;
    bit     br;
    bit     mis;
    bit     ill;
    longint bc;
    longint mc;
  } exp_t;

  exp_t   sb[$];
  int     npass = 0, ntot = 0;

  // Reference state
  int     m_bht[N];
  bit     m_v, m_br, m_mis, m_ill;
  longint m_bc, m_mc;

  task automatic chk(string n, longint act, longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", n, act, exp, $time);
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit taken_of(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb_;
    sa  = (a >= 32'h8000_0000) ? longint'(a) - 64'h1_0000_0000 : longint'(a);
    sb_ = (b >= 32'h8000_0000) ? longint'(b) - 64'h1_0000_0000 : longint'(b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb_;
      3'd5: return sa >= sb_;
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus: drive, check lookup against pre-edge table, step model.
  task automatic cyc(bit r, bit v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] pc, bit pred, bit st, bit fl, logic [31:0] ppc);
    exp_t e;
    bit   t;
    @(negedge clk);
    rst = r; bus.res_valid = v; bus.res_cmpop = op; bus.res_a = a; bus.res_b = b;
    bus.res_pc = pc; bus.res_pred = pred; bus.stall = st; bus.flush = fl; bus.pred_pc = ppc;
    #1;
    chk("pred_taken", longint'(bus.pred_taken), longint'(m_bht[idx_of(ppc)] >= 2));
    if (r) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_v = 0; m_br = 0; m_mis = 0; m_ill = 0; m_bc = 0; m_mc = 0;
    end else if (v && !st && !fl) begin
      t = taken_of(op, a, b);
      m_v = 1; m_br = t; m_mis = (t != pred); m_ill = (op == 3'd2 || op == 3'd3);
      if (!m_ill) begin
        if (t) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1;
        else   m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
        if (m_bc < SAT) m_bc++;
        if (m_mis && m_mc < SAT) m_mc++;
      end
    end else if (fl || !st) begin
      m_v = 0;
    end
    e.v = m_v; e.br = m_br; e.mis = m_mis; e.ill = m_ill; e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
  endtask

  task automatic idle(logic [31:0] ppc);
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, ppc);
  endtask

  // Absolute checks just after the edge that consumed the last cyc().
  task automatic post_cnt(string n, longint bc, longint mc);
    @(posedge clk); #2;
    chk({n, "_bc"}, longint'(bus.branch_count), bc);
    chk({n, "_mc"}, longint'(bus.mispredict_count), mc);
  endtask

  // Monitor: compare registered outputs with scoreboard each edge.
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("out_valid", longint'(bus.out_valid), longint'(me.v));
      if (me.v) begin
        chk("br_en",      longint'(bus.br_en),      longint'(me.br));
        chk("mispredict", longint'(bus.mispredict), longint'(me.mis));
        chk("illegal_op", longint'(bus.illegal_op), longint'(me.ill));
      end
      chk("branch_count",     longint'(bus.branch_count),     me.bc);
      chk("mispredict_count", longint'(bus.mispredict_count), me.mc);
    end
  end

  logic [31:0] pcs[5] = '{32'h100, 32'h104, 32'h200, 32'h108, 32'h10};
  logic [31:0] ops[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

  initial begin
    bus.res_valid = 0; bus.res_cmpop = 0; bus.res_a = 0; bus.res_b = 0;
    bus.res_pc = 0; bus.res_pred = 0; bus.stall = 0; bus.flush = 0; bus.pred_pc = 0;
    foreach (m_bht[i]) m_bht[i] = 1;

    // Signed vs unsigned
    cyc(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h10);
    cyc(0, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h10, 0, 0, 0, 32'h10);
    cyc(0, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h10, 0, 0, 0, 32'h10);
    cyc(0, 1, 3'd5, 32'hFFFF_FFFF, 1, 32'h10, 0, 0, 0, 32'h10);
    cyc(0, 1, 3'd7, 32'hFFFF_FFFF, 1, 32'h10, 0, 0, 0, 32'h10);
    idle(32'h10);
    post_cnt("signed", 4, 2);

    // Saturation at 0x100, then aliasing lookups
    cyc(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h100);
    for (int i = 0; i < 4; i++) cyc(0, 1, 3'd0, 5, 5, 32'h100, 0, 0, 0, 32'h100);
    idle(32'h100);
    post_cnt("sat", 4, 4);
    idle(32'h200);
    idle(32'h104);
    chk("alias_104", longint'(bus.pred_taken), 0);

    // Stall / flush
    cyc(0, 1, 3'd1, 1, 2, 32'h104, 0, 0, 0, 32'h104);
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'd1, 3, 3, 32'h104, 1, 1, 0, 32'h104);
    cyc(0, 1, 3'd0, 7, 7, 32'h104, 0, 1, 1, 32'h104);
    idle(32'h104);
    post_cnt("stallflush", 5, 5);

    // Illegal op
    cyc(0, 1, 3'd2, 9, 9, 32'h104, 1, 0, 0, 32'h104);
    cyc(0, 1, 3'd3, 9, 9, 32'h104, 0, 0, 0, 32'h104);
    idle(32'h104);
    post_cnt("illegal", 5, 5);

    // Reset with an op present; collision lookup
    cyc(1, 1, 3'd0, 5, 5, 32'h100, 0, 0, 0, 32'h100);
    idle(32'h100);
    chk("rst_pred", longint'(bus.pred_taken), 0);
    cyc(0, 1, 3'd0, 5, 5, 32'h100, 0, 0, 0, 32'h100);
    cyc(0, 1, 3'd0, 5, 5, 32'h100, 0, 0, 0, 32'h200);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(3) == 0) ? $urandom : ops[$urandom_range(5)];
      b = ($urandom_range(2) == 0) ? a : ops[$urandom_range(5)];
      cyc($urandom_range(60) == 0, $urandom_range(9) < 7, 3'($urandom_range(7)), a, b,
          ($urandom_range(7) == 0) ? $urandom : pcs[$urandom_range(4)],
          1'($urandom_range(1)), $urandom_range(4) == 0, $urandom_range(9) == 0,
          ($urandom_range(7) == 0) ? $urandom : pcs[$urandom_range(4)]);
    end
    idle(0);
    idle(0);
    @(posedge clk); #2;
    chk("sb_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
